// File: rtl/bar_graph_meter.sv
// ---------------------------------------------------------------------------
// bar_graph_meter
//
// Multi-channel LED bar-graph meter. Every channel turns an unsigned sample
// into a segment level using the MSB-position rule: segment i is lit when
// (data >> (i+LSB)) != 0. A new level takes effect at once (instant attack),
// then falls by one segment per decay tick. An optional held peak dot marks
// the recent maximum. The display is drawn as a filled bar (mode=0) or as a
// single dot at the level (mode=1).
//
// Build option:
//   BAR_PEAK_HOLD_EN  when defined, adds the peak registers, hold counters and
//                     the peak marker. When undefined, the display shows the
//                     level only and HOLD_TICKS has no effect.
//
// Ports:
//   clk   in   1                  system clock
//   rst   in   1                  synchronous, active-high reset
//   en    in   CHANNELS           per-channel sample strobe
//   data  in   CHANNELS*IN_WIDTH  channel c at [c*IN_WIDTH +: IN_WIDTH]
//   mode  in   1                  0 = bar (fill), 1 = dot
//   bar   out  CHANNELS*SEGMENTS  channel c at [c*SEGMENTS +: SEGMENTS],
//                                 bit 0 = bottom LED (registered)
// ---------------------------------------------------------------------------
module bar_graph_meter #(
  parameter int CHANNELS   = 2,
  parameter int IN_WIDTH   = 8,
  parameter int SEGMENTS   = 8,
  parameter int LSB        = 0,
  parameter int DECAY_DIV  = 1024,
  parameter int HOLD_TICKS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS*IN_WIDTH-1:0] data,
  input  logic                         mode,
  output logic [CHANNELS*SEGMENTS-1:0] bar
);

  // Level/peak range is 0..SEGMENTS inclusive.
  localparam int LW = $clog2(SEGMENTS + 1);
  // DECAY_DIV=1 would give a zero-width counter; keep one bit that stays 0.
  localparam int CW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  if (DECAY_DIV < 1 || HOLD_TICKS < 0) begin : g_param_check
    $error("bar_graph_meter: DECAY_DIV must be >= 1 and HOLD_TICKS >= 0");
  end

  // -------------------------------------------------------------------------
  // Shared decay prescaler
  // -------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick  = (cnt_q == CW'(DECAY_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // -------------------------------------------------------------------------
  // Sample-to-level conversion
  // -------------------------------------------------------------------------
  logic [LW-1:0] new_lvl [CHANNELS];

  // Counting every segment whose shifted word is nonzero gives the
  // MSB-position level directly. Segments mapped beyond the input width can
  // never count, so they never light from the level.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      new_lvl[c] = '0;
      for (int i = 0; i < SEGMENTS; i++) begin
        if ((i + LSB < IN_WIDTH) &&
            ((data[c*IN_WIDTH +: IN_WIDTH] >> (i + LSB)) != '0)) begin
          new_lvl[c] = new_lvl[c] + LW'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Level: instant attack, one-segment decay per tick
  // -------------------------------------------------------------------------
  logic [LW-1:0] lvl_q [CHANNELS];
  logic [LW-1:0] lvl_d [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      logic [LW-1:0] base;
      // On a tick the decayed value competes with the new sample, so a weak
      // strobe on a tick edge cannot stop the bar from falling.
      if (tick) begin
        base = (lvl_q[c] == '0) ? '0 : lvl_q[c] - LW'(1);
      end else begin
        base = lvl_q[c];
      end
      if (en[c] && (new_lvl[c] > base)) begin
        lvl_d[c] = new_lvl[c];
      end else begin
        lvl_d[c] = base;
      end
    end
  end

`ifdef BAR_PEAK_HOLD_EN
  // -------------------------------------------------------------------------
  // Peak hold: compared against the next level so pk >= lvl always holds
  // -------------------------------------------------------------------------
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [LW-1:0] pk_q   [CHANNELS];
  logic [LW-1:0] pk_d   [CHANNELS];
  logic [HW-1:0] hold_q [CHANNELS];
  logic [HW-1:0] hold_d [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      logic [LW-1:0] pk_dec;
      pk_dec    = (pk_q[c] == '0) ? '0 : pk_q[c] - LW'(1);
      pk_d[c]   = pk_q[c];
      hold_d[c] = hold_q[c];
      if (lvl_d[c] > pk_q[c]) begin
        pk_d[c]   = lvl_d[c];
        hold_d[c] = HW'(HOLD_TICKS);
      end else if (tick) begin
        if (hold_q[c] != '0) begin
          hold_d[c] = hold_q[c] - HW'(1);
        end else begin
          // The dot falls with the bar but never below it.
          pk_d[c] = (pk_dec > lvl_d[c]) ? pk_dec : lvl_d[c];
        end
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Display rendering (registered)
  // -------------------------------------------------------------------------
  logic [CHANNELS*SEGMENTS-1:0] bar_q, bar_d;

  always_comb begin
    bar_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < SEGMENTS; i++) begin
        logic lvl_bit;
        logic pk_bit;
        if (mode) begin
          lvl_bit = (lvl_q[c] == LW'(i + 1));
        end else begin
          lvl_bit = (lvl_q[c] > LW'(i));
        end
`ifdef BAR_PEAK_HOLD_EN
        pk_bit = (pk_q[c] == LW'(i + 1));
`else
        pk_bit = 1'b0;
`endif
        bar_d[c*SEGMENTS + i] = lvl_bit | pk_bit;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      bar_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        lvl_q[c] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      bar_q <= bar_d;
      for (int c = 0; c < CHANNELS; c++) begin
        lvl_q[c] <= lvl_d[c];
      end
    end
  end

`ifdef BAR_PEAK_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        pk_q[c]   <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        pk_q[c]   <= pk_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end
`endif

  assign bar = bar_q;

endmodule
